// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
//   Shared definitions for the interrupt pending/request stage.
//   - N_SRC_DEFAULT : default number of interrupt sources (timer + externals)
//   - TIMER_SRC     : source index reserved for the counter-stage expiry flag
//   - irq_state_t   : request/acknowledge/end-of-interrupt FSM states
// ---------------------------------------------------------------------------
package irq_pkg;

    localparam int N_SRC_DEFAULT = 8;
    localparam int TIMER_SRC     = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
//   Purely combinational lowest-index-first priority encoder.
//   Ports:
//     vec   in  N     request vector (bit 0 = highest priority)
//     valid out 1     at least one bit of vec is set
//     id    out ID_W  index of the lowest set bit (0 when valid = 0)
// ---------------------------------------------------------------------------
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N    = N_SRC_DEFAULT,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    vec,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    // Scanning from the top down lets the lowest set index overwrite last.
    always_comb begin
        valid = |vec;
        id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// ---------------------------------------------------------------------------
// irq_pending_ctrl
//   Latches rising edges of {irq_in, timer_ready} into a pending register,
//   picks the lowest-index enabled pending source and presents it to the
//   core through a req/ack/eoi handshake. Retiring the timer source (id 0)
//   emits a one-cycle timer_restart pulse to re-arm the counter stage.
//
//   Handshake: irq_req is held high with a stable irq_id until irq_ack is
//   sampled high; the source is then ACTIVE until irq_eoi is sampled high.
//   irq_ack outside REQ and irq_eoi outside ACTIVE are ignored; when both
//   arrive in the same REQ cycle only the ack takes effect.
//
//   Ports:
//     clk_in        in  1        system clock (rising edge)
//     RESET         in  1        synchronous, active-high reset
//     timer_ready   in  1        counter-stage expiry flag (source 0)
//     irq_in        in  N_SRC-1  external interrupt lines (sources 1..)
//     irq_mask      in  N_SRC    per-source request enable
//     irq_ack       in  1        core accepts the current request
//     irq_eoi       in  1        core finished servicing the active source
//     irq_req       out 1        interrupt request to the core
//     irq_id        out ID_W     index of requested / active source
//     pending       out N_SRC    latched pending bits (mask not applied)
//     timer_restart out 1        one-cycle counter re-arm pulse
//     fsm_state     out 2        current handshake state (debug view)
// ---------------------------------------------------------------------------
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEFAULT,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic             clk_in,
    input  logic             RESET,
    input  logic             timer_ready,
    input  logic [N_SRC-2:0] irq_in,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic             irq_ack,
    input  logic             irq_eoi,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] pending,
    output logic             timer_restart,
    output logic [1:0]       fsm_state
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_REQ    = REQ;
    localparam logic [1:0] ST_ACTIVE = ACTIVE;

    logic [N_SRC-1:0] src;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] pend_next;
    logic [N_SRC-1:0] enabled;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [ID_W-1:0]  id_next;
    logic             restart_next;
    logic             win_valid;
    logic [ID_W-1:0]  win_id;

    assign src     = {irq_in, timer_ready};
    assign rise    = src & ~src_q;
    assign enabled = pending & irq_mask;

    irq_prio_enc #(
        .N    (N_SRC),
        .ID_W (ID_W)
    ) u_prio_enc (
        .vec   (enabled),
        .valid (win_valid),
        .id    (win_id)
    );

    always_comb begin
        state_next   = state;
        id_next      = irq_id;
        restart_next = 1'b0;
        clr          = '0;
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    id_next    = win_id;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                // Mask changes here do not withdraw the request.
                if (irq_ack) begin
                    clr[irq_id] = 1'b1;
                    state_next  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (irq_eoi) begin
                    state_next   = ST_IDLE;
                    restart_next = (irq_id == ID_W'(TIMER_SRC));
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // A fresh edge in the same cycle as the ack clear keeps the bit set.
    assign pend_next = (pending & ~clr) | rise;

    always_ff @(posedge clk_in) begin
        // src_q tracks src even in reset so a line already high at
        // reset release is not seen as an edge.
        src_q <= src;
        if (RESET) begin
            state         <= ST_IDLE;
            irq_id        <= '0;
            pending       <= '0;
            irq_req       <= 1'b0;
            timer_restart <= 1'b0;
        end else begin
            state         <= state_next;
            irq_id        <= id_next;
            pending       <= pend_next;
            irq_req       <= (state_next == ST_REQ);
            timer_restart <= restart_next;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_pending_ctrl
//   Table-driven vectors, hand-written corner sequences and a randomized
//   phase checked against a cycle-level reference model of the controller.
// ---------------------------------------------------------------------------
module tb_irq_pending_ctrl;
    import irq_pkg::*;

    localparam int N  = 8;
    localparam int IW = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          timer_ready;
    logic [N-2:0]  irq_in;
    logic [N-1:0]  irq_mask;
    logic          irq_ack;
    logic          irq_eoi;
    logic          irq_req;
    logic [IW-1:0] irq_id;
    logic [N-1:0]  pending;
    logic          timer_restart;
    logic [1:0]    fsm_state;

    irq_pending_ctrl #(.N_SRC(N), .ID_W(IW)) dut (
        .clk_in        (clk),
        .RESET         (rst),
        .timer_ready   (timer_ready),
        .irq_in        (irq_in),
        .irq_mask      (irq_mask),
        .irq_ack       (irq_ack),
        .irq_eoi       (irq_eoi),
        .irq_req       (irq_req),
        .irq_id        (irq_id),
        .pending       (pending),
        .timer_restart (timer_restart),
        .fsm_state     (fsm_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic t, input logic [N-2:0] in,
                         input logic [N-1:0] m, input logic a, input logic e);
        rst = r; timer_ready = t; irq_in = in; irq_mask = m; irq_ack = a; irq_eoi = e;
    endtask

    // ---------------- reference model ----------------
    // Phases: 0 idle, 1 request outstanding, 2 being serviced.
    bit [N-1:0] m_pend, m_prev;
    int         m_phase, m_id;
    bit         m_req, m_trs;

    task automatic model_step();
        bit [N-1:0] s;
        bit [N-1:0] newpend;
        int         w;
        s = {irq_in, timer_ready};
        if (rst) begin
            m_pend = '0; m_phase = 0; m_id = 0; m_req = 0; m_trs = 0;
        end else begin
            newpend = m_pend | (s & ~m_prev);
            m_trs = 0;
            if (m_phase == 0) begin
                w = -1;
                for (int i = N - 1; i >= 0; i--)
                    if (m_pend[i] && irq_mask[i]) w = i;
                if (w >= 0) begin m_id = w; m_phase = 1; end
            end else if (m_phase == 1) begin
                if (irq_ack) begin
                    m_phase = 2;
                    if (!(s[m_id] && !m_prev[m_id])) newpend[m_id] = 1'b0;
                end
            end else if (irq_eoi) begin
                m_phase = 0;
                m_trs = (m_id == TIMER_SRC);
            end
            m_pend = newpend;
            m_req = (m_phase == 1);
        end
        m_prev = s;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          r;
        logic          t;
        logic [N-2:0]  in;
        logic [N-1:0]  m;
        logic          a;
        logic          e;
        logic          x_req;
        logic [IW-1:0] x_id;
        logic [N-1:0]  x_pend;
        logic          x_trs;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic t, logic [N-2:0] in, logic [N-1:0] m,
                                logic a, logic e, logic xr, logic [IW-1:0] xi,
                                logic [N-1:0] xp, logic xt);
        vec_t v;
        v.r = r; v.t = t; v.in = in; v.m = m; v.a = a; v.e = e;
        v.x_req = xr; v.x_id = xi; v.x_pend = xp; v.x_trs = xt;
        return v;
    endfunction

    int wait_n;

    initial begin
        drive(1, 0, '0, '0, 0, 0);
        // Priority: sources 5 and 2 together, then queued service.
        tbl.push_back(mk(1, 0, 7'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 7'h12, 8'hFF, 0, 0, 0, 0, 8'h24, 0));
        tbl.push_back(mk(0, 0, 7'h00, 8'hFF, 0, 0, 1, 2, 8'h24, 0));
        tbl.push_back(mk(0, 0, 7'h00, 8'hFF, 1, 1, 0, 2, 8'h20, 0));
        tbl.push_back(mk(0, 0, 7'h00, 8'hFF, 0, 0, 0, 2, 8'h20, 0));
        tbl.push_back(mk(0, 0, 7'h00, 8'hFF, 0, 1, 0, 2, 8'h20, 0));
        tbl.push_back(mk(0, 0, 7'h00, 8'hFF, 0, 0, 1, 5, 8'h20, 0));
        tbl.push_back(mk(0, 0, 7'h00, 8'hFF, 1, 0, 0, 5, 8'h00, 0));
        tbl.push_back(mk(0, 0, 7'h00, 8'hFF, 0, 1, 0, 5, 8'h00, 0));
        tbl.push_back(mk(0, 0, 7'h00, 8'hFF, 0, 0, 0, 5, 8'h00, 0));
        // Timer path: level held two cycles, ack, eoi with stray ack.
        tbl.push_back(mk(0, 1, 7'h00, 8'h01, 0, 0, 0, 5, 8'h01, 0));
        tbl.push_back(mk(0, 1, 7'h00, 8'h01, 0, 0, 1, 0, 8'h01, 0));
        tbl.push_back(mk(0, 0, 7'h00, 8'h01, 0, 0, 1, 0, 8'h01, 0));
        tbl.push_back(mk(0, 0, 7'h00, 8'h01, 1, 0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 7'h00, 8'h01, 1, 1, 0, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 7'h00, 8'h01, 0, 0, 0, 0, 8'h00, 0));
        // eoi / ack in IDLE are ignored.
        tbl.push_back(mk(0, 0, 7'h00, 8'h01, 0, 1, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 7'h00, 8'h01, 1, 0, 0, 0, 8'h00, 0));

        foreach (tbl[k]) begin
            drive(tbl[k].r, tbl[k].t, tbl[k].in, tbl[k].m, tbl[k].a, tbl[k].e);
            tick();
            chk($sformatf("tbl%0d.req", k), 32'(irq_req), 32'(tbl[k].x_req));
            chk($sformatf("tbl%0d.id", k), 32'(irq_id), 32'(tbl[k].x_id));
            chk($sformatf("tbl%0d.pend", k), 32'(pending), 32'(tbl[k].x_pend));
            chk($sformatf("tbl%0d.trs", k), 32'(timer_restart), 32'(tbl[k].x_trs));
        end

        // ---- masked source latches but does not request ----
        drive(1, 0, '0, 8'h00, 0, 0); tick();
        rst = 0; irq_in = 7'h04; tick();
        chk("mask.pend", 32'(pending), 32'h08);
        tick(); tick();
        chk("mask.noreq", 32'(irq_req), 32'h0);
        irq_mask = 8'h08;
        wait_n = 0;
        while (!irq_req && wait_n < 4) begin tick(); wait_n++; end
        chk("mask.req", 32'(irq_req), 32'h1);
        chk("mask.id", 32'(irq_id), 32'h3);

        // ---- set/clear collision on source 4 ----
        drive(1, 0, '0, 8'hFF, 0, 0); tick();
        rst = 0; irq_in = 7'h08; tick();
        irq_in = 7'h00; tick();
        chk("coll.req", 32'(irq_req), 32'h1);
        chk("coll.id", 32'(irq_id), 32'h4);
        irq_in = 7'h08; irq_ack = 1; tick();
        irq_ack = 0;
        chk("coll.pend", 32'(pending), 32'h10);
        chk("coll.reqlow", 32'(irq_req), 32'h0);
        irq_eoi = 1; tick(); irq_eoi = 0; tick();
        chk("coll.rereq", 32'(irq_req), 32'h1);
        chk("coll.reid", 32'(irq_id), 32'h4);

        // ---- level held across reset release ----
        drive(1, 0, 7'h01, 8'hFF, 0, 0); tick(); tick();
        rst = 0; tick(); tick(); tick();
        chk("lvl.pend", 32'(pending), 32'h0);
        chk("lvl.noreq", 32'(irq_req), 32'h0);
        irq_in = 7'h00; tick();
        irq_in = 7'h01; tick();
        chk("lvl.pend1", 32'(pending), 32'h02);
        tick();
        chk("lvl.req", 32'(irq_req), 32'h1);
        chk("lvl.id", 32'(irq_id), 32'h1);
        irq_ack = 1; tick(); irq_ack = 0;
        irq_eoi = 1; tick(); irq_eoi = 0;
        tick(); tick();
        chk("lvl.once.req", 32'(irq_req), 32'h0);
        chk("lvl.once.pend", 32'(pending), 32'h0);

        // ---- ack in ACTIVE ignored, then reset while ACTIVE ----
        drive(1, 0, '0, 8'h01, 0, 0); tick();
        rst = 0; timer_ready = 1; tick();
        timer_ready = 0; tick();
        chk("rst.req", 32'(irq_req), 32'h1);
        irq_ack = 1; tick();
        chk("rst.active", 32'(fsm_state), 32'(ACTIVE));
        tick(); irq_ack = 0;
        chk("viol.state", 32'(fsm_state), 32'(ACTIVE));
        chk("viol.pend", 32'(pending), 32'h0);
        chk("viol.trs", 32'(timer_restart), 32'h0);
        rst = 1; irq_eoi = 1; tick();
        chk("rst.req0", 32'(irq_req), 32'h0);
        chk("rst.id0", 32'(irq_id), 32'h0);
        chk("rst.pend0", 32'(pending), 32'h0);
        chk("rst.trs0", 32'(timer_restart), 32'h0);
        chk("rst.idle", 32'(fsm_state), 32'(IDLE));
        rst = 0; irq_eoi = 0; tick();
        chk("rst.trs1", 32'(timer_restart), 32'h0);

        // ---- randomized phase against the reference model ----
        m_prev = '0;
        for (int c = 0; c < 1500; c++) begin
            rst = (c == 0) || ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) timer_ready = ~timer_ready;
            irq_in = irq_in ^ (7'($urandom) & 7'($urandom) & 7'($urandom));
            if ($urandom_range(0, 15) == 0) irq_mask = 8'($urandom);
            irq_ack = ($urandom_range(0, 2) == 0);
            irq_eoi = ($urandom_range(0, 2) == 0);
            model_step();
            tick();
            chk("rnd.req", 32'(irq_req), 32'(m_req));
            chk("rnd.id", 32'(irq_id), 32'(m_id));
            chk("rnd.pend", 32'(pending), 32'(m_pend));
            chk("rnd.trs", 32'(timer_restart), 32'(m_trs));
            chk("rnd.state", 32'(fsm_state), 32'(m_phase));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
